// File: rtl/sccb_write_arbiter_pkg.sv
// Shared types and helpers for the SCCB write arbiter and its round-robin picker.
// Word layout is {reg_addr[15:0], value[7:0]}; reg_addr DELAY_ADDR marks a millisecond delay.
package sccb_pkg;

  localparam logic [15:0] DELAY_ADDR  = 16'hFFFF;
  localparam int          SCCB_WORD_W = 24;
  localparam int          MAX_REQ     = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RELEASE,
    DELAY,
    DONE
  } arb_state_t;

  // Callers zero-extend their flattened bus to MAX_REQ slots.
  function automatic logic [SCCB_WORD_W-1:0] get_slot(
    input logic [SCCB_WORD_W*MAX_REQ-1:0] flat,
    input int                             idx
  );
    return SCCB_WORD_W'(flat >> (idx * SCCB_WORD_W));
  endfunction

endpackage

// File: rtl/sccb_write_arbiter_if.sv
// Requester and engine-side bundle of the SCCB write arbiter.
// master drives requests and the engine ack; slave is the arbiter.
interface sccb_write_arbiter_if
  import sccb_pkg::*;
#(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [SCCB_WORD_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_done;
  logic [NUM_REQ-1:0]             req_err;
  logic [31:0]                    i2c_data;
  logic                           i2c_req;
  logic                           i2c_ack;
  logic                           busy;
  logic [NUM_REQ-1:0]             grant;

  modport master (
    output req_valid, req_data, i2c_ack,
    input  req_done, req_err, i2c_data, i2c_req, busy, grant
  );

  modport slave (
    input  req_valid, req_data, i2c_ack,
    output req_done, req_err, i2c_data, i2c_req, busy, grant
  );

endinterface

// File: rtl/sccb_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping at N-1.
// Zero latency; no state, the caller owns ptr and decides when a pick is taken.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [N-1:0] sel;
  int           j;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    sel = '0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      sel = N'(1) << j;
      if (!vld && (req & sel) != '0) begin
        gnt = sel;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sccb_write_arbiter.sv
// Shares one SCCB write engine among NUM_REQ requesters with four-phase req/ack and in-stream ms delays.
// Grant 1 cycle after req_valid; requesters hold valid until req_done, nothing is queued internally.
module sccb_write_arbiter
  import sccb_pkg::*;
#(
  parameter int          NUM_REQ     = 3,
  parameter logic [7:0]  DEV_ADDR    = 8'h78,
  parameter int          MS_CYCLES   = 25000,
  parameter int          ACK_TIMEOUT = 2_500_000
) (
  input  logic                 clk_25M,
  input  logic                 rst_100,
  sccb_write_arbiter_if.slave  bus
);

  localparam int PW    = $clog2(NUM_REQ);
  localparam int DLY_W = $clog2(255 * MS_CYCLES + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  arb_state_t                   state;
  logic                         ack_m;
  logic                         ack_s;
  logic                         ack_wait;
  logic [PW-1:0]                rr_ptr;
  logic [DLY_W-1:0]             dly_cnt;
  logic [TO_W-1:0]              to_cnt;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           req_done;
  logic [NUM_REQ-1:0]           req_err;
  logic [31:0]                  i2c_data;
  logic                         i2c_req;
  logic                         busy;

  logic [NUM_REQ-1:0]           pick;
  logic                         pick_vld;
  logic [PW-1:0]                win_idx;
  logic [PW-1:0]                next_ptr;
  logic [SCCB_WORD_W*MAX_REQ-1:0] data_ext;
  logic [SCCB_WORD_W-1:0]       win_word;
  logic                         to_hit;

  always_ff @(posedge clk_25M or posedge rst_100) begin
    if (rst_100) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= bus.i2c_ack;
      ack_s <= ack_m;
    end
  end

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick),
    .vld (pick_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((pick & (NUM_REQ'(1) << i)) != '0) win_idx = PW'(i);
    end
    data_ext = '0;
    data_ext[SCCB_WORD_W*NUM_REQ-1:0] = bus.req_data;
  end

  assign win_word = get_slot(data_ext, int'(win_idx));
  assign next_ptr = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
  assign to_hit   = (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk_25M or posedge rst_100) begin
    if (rst_100) begin
      state    <= IDLE;
      i2c_req  <= 1'b0;
      i2c_data <= '0;
      req_done <= '0;
      req_err  <= '0;
      busy     <= 1'b0;
      grant    <= '0;
      rr_ptr   <= '0;
      dly_cnt  <= '0;
      to_cnt   <= '0;
      ack_wait <= 1'b0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      case (state)
        IDLE: begin
          if (!ack_s) ack_wait <= 1'b0;
          // After a timeout the engine may still hold ack; it must clear before a new request.
          if (pick_vld && (!ack_wait || !ack_s)) begin
            grant  <= pick;
            rr_ptr <= next_ptr;
            busy   <= 1'b1;
            to_cnt <= '0;
            if (win_word[23:8] == DELAY_ADDR) begin
              state   <= DELAY;
              dly_cnt <= DLY_W'(win_word[7:0]) * DLY_W'(MS_CYCLES);
            end else begin
              state    <= SEND;
              i2c_data <= {DEV_ADDR, win_word};
              i2c_req  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (ack_s) begin
            i2c_req <= 1'b0;
            to_cnt  <= '0;
            state   <= RELEASE;
          end else if (to_hit) begin
            i2c_req  <= 1'b0;
            ack_wait <= 1'b1;
            req_done <= grant;
            req_err  <= grant;
            state    <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            req_done <= grant;
            state    <= DONE;
          end else if (to_hit) begin
            ack_wait <= 1'b1;
            req_done <= grant;
            req_err  <= grant;
            state    <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DELAY: begin
          if (dly_cnt == '0) begin
            req_done <= grant;
            state    <= DONE;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_done = req_done;
  assign bus.req_err  = req_err;
  assign bus.i2c_data = i2c_data;
  assign bus.i2c_req  = i2c_req;
  assign bus.busy     = busy;
  assign bus.grant    = grant;

endmodule
